// File: rtl/cvxif_router_pkg.sv
// Shared definitions for the CV-X-IF coprocessor router.
//   router_cfg_t       : bundle of the router's size parameters
//   CUSTOM0..CUSTOM3   : RISC-V custom major opcodes that channels can own
//   res_t              : result record {id, data, rd, we} at the default widths
//   idx_width()        : width of an index into n items (at least one bit)
package cvxif_router_pkg;

  localparam logic [6:0] CUSTOM0 = 7'b0001011;
  localparam logic [6:0] CUSTOM1 = 7'b0101011;
  localparam logic [6:0] CUSTOM2 = 7'b1011011;
  localparam logic [6:0] CUSTOM3 = 7'b1111011;

  typedef struct packed {
    int unsigned nr_copro;
    int unsigned id_width;
    int unsigned data_width;
    int unsigned max_outstanding;
  } router_cfg_t;

  localparam router_cfg_t DefaultRouterCfg = '{
    nr_copro:        2,
    id_width:        3,
    data_width:      64,
    max_outstanding: 4
  };

  localparam int unsigned ResIdWidth   = DefaultRouterCfg.id_width;
  localparam int unsigned ResDataWidth = DefaultRouterCfg.data_width;

  // Result as seen by the core when the router runs at its default widths.
  typedef struct packed {
    logic [ResIdWidth-1:0]   id;
    logic [ResDataWidth-1:0] data;
    logic [4:0]              rd;
    logic                    we;
  } res_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cvxif_router_rr_arb.sv
// Round-robin arbiter over N requesters.
//   req : request vector
//   ptr : highest-priority requester for this decision
//   gnt : one-hot grant (all zero when nobody requests)
//   idx : binary index of the granted requester (0 when nobody requests)
// Purely combinational; the caller owns and advances the pointer.
module cvxif_router_rr_arb #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  // Scan offsets 0..N-1 from ptr; the inner loop turns the rotated position
  // back into a constant index so no variable bit-select is needed.
  always_comb begin
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!found && req[j] && ((int'(ptr) + i) % int'(N)) == j) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = IdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cvxif_coproc_router.sv
// Routes CV-X-IF issue requests from one core to NrCopro coprocessors by major
// opcode and merges their results onto one registered result channel.
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   issue_*                       : core issue channel (combinational routing)
//   cp_issue_*, cp_instr/id/rs_o  : per-channel issue valid/ready, broadcast fields
//   cp_res_*                      : per-channel packed results with valid/ready
//   res_*                         : merged result to the core, res_src_o = channel
//   err_o                         : sticky, a channel returned more results than issued
module cvxif_coproc_router import cvxif_router_pkg::*; #(
  parameter int unsigned          NrCopro        = DefaultRouterCfg.nr_copro,
  parameter int unsigned          IdWidth        = DefaultRouterCfg.id_width,
  parameter int unsigned          DataWidth      = DefaultRouterCfg.data_width,
  parameter int unsigned          MaxOutstanding = DefaultRouterCfg.max_outstanding,
  // Channel k owns the opcode in bits [7k+6:7k] (channel 0 in the low bits).
  parameter logic [NrCopro*7-1:0] OpcodeSel      = {CUSTOM1, CUSTOM0},
  localparam int unsigned         SrcW           = idx_width(NrCopro)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  output logic                           issue_accept_o,
  input  logic [31:0]                    issue_instr_i,
  input  logic [IdWidth-1:0]             issue_id_i,
  input  logic [2*DataWidth-1:0]         issue_rs_i,
  output logic [NrCopro-1:0]             cp_issue_valid_o,
  input  logic [NrCopro-1:0]             cp_issue_ready_i,
  output logic [31:0]                    cp_instr_o,
  output logic [IdWidth-1:0]             cp_id_o,
  output logic [2*DataWidth-1:0]         cp_rs_o,
  input  logic [NrCopro-1:0]             cp_res_valid_i,
  output logic [NrCopro-1:0]             cp_res_ready_o,
  input  logic [NrCopro*IdWidth-1:0]     cp_res_id_i,
  input  logic [NrCopro*DataWidth-1:0]   cp_res_data_i,
  input  logic [NrCopro*5-1:0]           cp_res_rd_i,
  input  logic [NrCopro-1:0]             cp_res_we_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [IdWidth-1:0]             res_id_o,
  output logic [DataWidth-1:0]           res_data_o,
  output logic [4:0]                     res_rd_o,
  output logic                           res_we_o,
  output logic [SrcW-1:0]                res_src_o,
  output logic                           err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [4:0]           rd;
    logic                 we;
  } entry_t;

  logic [CntW-1:0]    cnt_reg [NrCopro];
  logic [NrCopro-1:0] match, iss_hs, res_hs, underflow;
  logic               hit, full;
  logic [SrcW-1:0]    sel;

  // Issue routing --------------------------------------------------------
  assign cp_instr_o = issue_instr_i;
  assign cp_id_o    = issue_id_i;
  assign cp_rs_o    = issue_rs_i;

  generate
    for (genvar gi = 0; gi < NrCopro; gi++) begin : g_chan
      assign match[gi]     = (issue_instr_i[6:0] == OpcodeSel[gi*7 +: 7]);
      assign iss_hs[gi]    = cp_issue_valid_o[gi] & cp_issue_ready_i[gi];
      assign res_hs[gi]    = cp_res_valid_i[gi] & cp_res_ready_o[gi];
      assign underflow[gi] = res_hs[gi] && (cnt_reg[gi] == '0);
    end
  endgenerate

  // Downward scan so the lowest matching channel is the one left in sel.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = int'(NrCopro) - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit = 1'b1;
        sel = SrcW'(k);
      end
    end
  end

  assign full = (cnt_reg[sel] == CntW'(MaxOutstanding));

  // Unrouted opcodes complete at once as rejected; a routed opcode with no
  // credit left stalls the core rather than overflowing the channel.
  always_comb begin
    cp_issue_valid_o = '0;
    issue_ready_o    = 1'b1;
    issue_accept_o   = 1'b0;
    if (hit) begin
      issue_accept_o = 1'b1;
      if (full) begin
        issue_ready_o = 1'b0;
      end else begin
        cp_issue_valid_o[sel] = issue_valid_i;
        issue_ready_o         = cp_issue_ready_i[sel];
      end
    end
  end

  // Credits ----------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(NrCopro); k++) cnt_reg[k] <= '0;
      err_o <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NrCopro); k++) begin
        if (iss_hs[k] && !res_hs[k]) begin
          cnt_reg[k] <= cnt_reg[k] + CntW'(1);
        end else if (res_hs[k] && !iss_hs[k] && cnt_reg[k] != '0) begin
          cnt_reg[k] <= cnt_reg[k] - CntW'(1);
        end
      end
      if (|underflow) err_o <= 1'b1;
    end
  end

  // Result merge -------------------------------------------------------------
  logic               res_valid_reg, load;
  entry_t             res_reg, cand;
  logic [SrcW-1:0]    src_reg, rr_ptr_reg, gnt_idx;
  logic [NrCopro-1:0] gnt;

  cvxif_router_rr_arb #(.N(NrCopro), .IdxW(SrcW)) u_arb (
    .req (cp_res_valid_i),
    .ptr (rr_ptr_reg),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Loading whenever the slot is empty or being drained gives one result per
  // cycle without a bubble; while stalled no channel sees ready.
  assign load           = !res_valid_reg || res_ready_i;
  assign cp_res_ready_o = load ? gnt : '0;

  always_comb begin
    cand = '0;
    for (int k = 0; k < int'(NrCopro); k++) begin
      if (gnt[k]) begin
        cand.id   = cp_res_id_i[k*IdWidth +: IdWidth];
        cand.data = cp_res_data_i[k*DataWidth +: DataWidth];
        cand.rd   = cp_res_rd_i[k*5 +: 5];
        cand.we   = cp_res_we_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_valid_reg <= 1'b0;
      res_reg       <= '0;
      src_reg       <= '0;
      rr_ptr_reg    <= '0;
    end else if (load) begin
      if (|cp_res_valid_i) begin
        res_valid_reg <= 1'b1;
        res_reg       <= cand;
        src_reg       <= gnt_idx;
        rr_ptr_reg    <= (gnt_idx == SrcW'(NrCopro - 1)) ? '0 : gnt_idx + SrcW'(1);
      end else begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign res_valid_o = res_valid_reg;
  assign res_id_o    = res_reg.id;
  assign res_data_o  = res_reg.data;
  assign res_rd_o    = res_reg.rd;
  assign res_we_o    = res_reg.we;
  assign res_src_o   = src_reg;

  // Handshake stability expected from the core and the coprocessors.
  a_issue_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (issue_valid_i && !issue_ready_o) |=>
      (issue_valid_i && $stable(issue_instr_i) && $stable(issue_id_i) && $stable(issue_rs_i)));

  generate
    for (genvar gi = 0; gi < NrCopro; gi++) begin : g_res_chk
      a_res_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cp_res_valid_i[gi] && !cp_res_ready_o[gi]) |=>
          (cp_res_valid_i[gi] && $stable(cp_res_id_i[gi*IdWidth +: IdWidth]) &&
           $stable(cp_res_data_i[gi*DataWidth +: DataWidth]) &&
           $stable(cp_res_rd_i[gi*5 +: 5]) && $stable(cp_res_we_i[gi])));
    end
  endgenerate

endmodule

// File: tb/tb_cvxif_coproc_router.sv
module tb_cvxif_coproc_router;

  localparam int N = 2, IW = 3, DW = 64, MAXO = 4;
  localparam logic [N-1:0] ONE = 1;

  logic            clk, rst_n;
  logic            issue_valid, issue_ready, issue_accept;
  logic [31:0]     issue_instr;
  logic [IW-1:0]   issue_id;
  logic [2*DW-1:0] issue_rs;
  logic [N-1:0]    cp_issue_valid, cp_issue_ready;
  logic [31:0]     cp_instr;
  logic [IW-1:0]   cp_id;
  logic [2*DW-1:0] cp_rs;
  logic [N-1:0]    cp_res_valid, cp_res_ready;
  logic [N*IW-1:0] cp_res_id;
  logic [N*DW-1:0] cp_res_data;
  logic [N*5-1:0]  cp_res_rd;
  logic [N-1:0]    cp_res_we;
  logic            res_valid, res_ready;
  logic [IW-1:0]   res_id;
  logic [DW-1:0]   res_data;
  logic [4:0]      res_rd;
  logic            res_we;
  logic [0:0]      res_src;
  logic            err;

  cvxif_coproc_router #(
    .NrCopro(N), .IdWidth(IW), .DataWidth(DW), .MaxOutstanding(MAXO),
    .OpcodeSel({7'b0101011, 7'b0001011})
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_accept_o(issue_accept),
    .issue_instr_i(issue_instr), .issue_id_i(issue_id), .issue_rs_i(issue_rs),
    .cp_issue_valid_o(cp_issue_valid), .cp_issue_ready_i(cp_issue_ready),
    .cp_instr_o(cp_instr), .cp_id_o(cp_id), .cp_rs_o(cp_rs),
    .cp_res_valid_i(cp_res_valid), .cp_res_ready_o(cp_res_ready),
    .cp_res_id_i(cp_res_id), .cp_res_data_i(cp_res_data), .cp_res_rd_i(cp_res_rd),
    .cp_res_we_i(cp_res_we),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_data_o(res_data), .res_rd_o(res_rd), .res_we_o(res_we),
    .res_src_o(res_src), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]   opc_tab [N];
  int           m_cnt [N];
  int           m_rr, m_src;
  bit           m_valid, m_err;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_data;
  logic [4:0]    m_rd;
  logic          m_we;
  bit            e_ready, e_accept;
  logic [N-1:0]  e_cpv, e_cprr;

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_rr = 0; m_src = 0; m_valid = 0; m_err = 0;
    m_id = '0; m_data = '0; m_rd = '0; m_we = 1'b0;
  endtask

  task automatic model_comb();
    int hit;
    hit = -1;
    for (int k = 0; k < N; k++)
      if (hit < 0 && issue_instr[6:0] == opc_tab[k]) hit = k;
    e_cpv = '0; e_ready = 1; e_accept = 0;
    if (hit >= 0) begin
      e_accept = 1;
      if (m_cnt[hit] >= MAXO) e_ready = 0;
      else begin
        e_cpv   = issue_valid ? (ONE << hit) : '0;
        e_ready = ((cp_issue_ready >> hit) & ONE) != '0;
      end
    end
    e_cprr = '0;
    if (!m_valid || res_ready)
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (e_cprr == '0 && (((cp_res_valid >> c) & ONE) != '0)) e_cprr = ONE << c;
      end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      bit inc, dec;
      inc = e_cpv[k] && cp_issue_ready[k];
      dec = cp_res_valid[k] && e_cprr[k];
      if (dec && m_cnt[k] == 0) m_err = 1;
      if (inc && !dec) m_cnt[k]++;
      else if (dec && !inc && m_cnt[k] > 0) m_cnt[k]--;
    end
    if (!m_valid || res_ready) begin
      if (e_cprr != '0) begin
        int g;
        g = 0;
        for (int k = 0; k < N; k++) if (e_cprr[k]) g = k;
        m_valid = 1;
        m_id    = cp_res_id[g*IW +: IW];
        m_data  = cp_res_data[g*DW +: DW];
        m_rd    = cp_res_rd[g*5 +: 5];
        m_we    = cp_res_we[g];
        m_src   = g;
        m_rr    = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // One clock: compare everything at the falling edge, advance the model,
  // return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_comb();
    if (rst_n) begin
      chk("issue_ready", issue_ready, e_ready);
      if (e_ready) chk("issue_accept", issue_accept, e_accept);
      chk("cp_issue_valid", cp_issue_valid, e_cpv);
      chk("cp_res_ready", cp_res_ready, e_cprr);
      chk("cp_instr_bcast", cp_instr, issue_instr);
      chk("cp_id_bcast", cp_id, issue_id);
      chk("res_valid", res_valid, m_valid);
      chk("err", err, m_err);
      if (m_valid) begin
        chk("res_id", res_id, m_id);
        chk("res_data", res_data, m_data);
        chk("res_rd", res_rd, m_rd);
        chk("res_we", res_we, m_we);
        chk("res_src", res_src, m_src);
      end
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int k, input logic [IW-1:0] id, input logic [DW-1:0] d,
                         input logic [4:0] rd, input logic we);
    cp_res_id[k*IW +: IW]   = id;
    cp_res_data[k*DW +: DW] = d;
    cp_res_rd[k*5 +: 5]     = rd;
    cp_res_we[k]            = we;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [6:0] op;
    logic       vld;
    logic [1:0] cprdy;
    logic       e_rdy;
    logic       e_acc;
    logic [1:0] e_cpv;
    string      nm;
  } vec_t;
  vec_t tab [6];

  localparam logic [DW-1:0] DA = 64'hA0A0_1111_2222_0000;
  localparam logic [DW-1:0] DB = 64'hB0B0_3333_4444_0001;
  localparam logic [DW-1:0] D1 = 64'hD1D1_5555_6666_0002;

  bit           iss_hold;
  bit [N-1:0]   res_hold;

  initial begin
    opc_tab[0] = 7'h0B;
    opc_tab[1] = 7'h2B;
    tab[0] = '{7'h0B, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, "custom0_hs"};
    tab[1] = '{7'h33, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, "op_reject"};
    tab[2] = '{7'h2B, 1'b1, 2'b01, 1'b0, 1'b1, 2'b10, "custom1_wait"};
    tab[3] = '{7'h2B, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, "custom1_hs"};
    tab[4] = '{7'h5B, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, "custom2_reject"};
    tab[5] = '{7'h0B, 1'b0, 2'b11, 1'b1, 1'b1, 2'b00, "custom0_idle"};

    model_reset();
    rst_n = 0; issue_valid = 0; issue_instr = '0; issue_id = '0; issue_rs = '0;
    cp_issue_ready = '0; cp_res_valid = '0; cp_res_id = '0; cp_res_data = '0;
    cp_res_rd = '0; cp_res_we = '0; res_ready = 1;
    @(posedge clk); #1;
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_src", res_src, 0);
    chk("rst_err", err, 0);

    // Issue path table from reset state.
    issue_id = 3'd1;
    issue_rs = {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
    for (int i = 0; i < 6; i++) begin
      issue_instr = {25'h0, tab[i].op};
      issue_valid = tab[i].vld;
      cp_issue_ready = tab[i].cprdy;
      #1;
      chk({tab[i].nm, "_ready"}, issue_ready, tab[i].e_rdy);
      if (tab[i].e_rdy) chk({tab[i].nm, "_accept"}, issue_accept, tab[i].e_acc);
      chk({tab[i].nm, "_cpv"}, cp_issue_valid, tab[i].e_cpv);
      tick();
    end

    // Fill ch1 to its credit limit (already holds one), then stall.
    issue_instr = {25'h0, 7'h2B}; issue_id = 3'd2; issue_valid = 1; cp_issue_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fill_ready", issue_ready, 1);
      tick();
    end
    #1;
    chk("stall_ready", issue_ready, 0);
    chk("stall_cpv", cp_issue_valid, 2'b00);
    tick();
    set_res(1, 3'd5, D1, 5'd7, 1'b1);
    cp_res_valid = 2'b10; res_ready = 1;
    #1;
    chk("stall_same_cycle", issue_ready, 0);
    chk("stall_res_ready", cp_res_ready, 2'b10);
    tick();
    cp_res_valid = 2'b00;
    #1;
    chk("stall_release", issue_ready, 1);
    chk("stall_res_valid", res_valid, 1);
    chk("stall_res_src", res_src, 1);
    chk("stall_res_data", res_data, D1);
    tick();
    issue_valid = 0;

    // Both channels request every cycle: grants alternate from channel 0.
    set_res(0, 3'd2, DA, 5'd3, 1'b0);
    set_res(1, 3'd6, DB, 5'd9, 1'b1);
    cp_res_valid = 2'b11; res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", cp_res_ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
      chk("rr_src", res_src, i % 2);
      chk("rr_data", res_data, (i % 2) ? DB : DA);
      chk("rr_id", res_id, (i % 2) ? 3'd6 : 3'd2);
    end

    // Backpressure: output held, no channel ready.
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_cp_ready", cp_res_ready, 2'b00);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, DB);
      chk("hold_src", res_src, 1);
      tick();
    end
    res_ready = 1;
    #1;
    chk("release_grant", cp_res_ready, 2'b01);
    tick();
    chk("release_src0", res_src, 0);
    chk("release_data0", res_data, DA);
    cp_res_valid = 2'b10;
    tick();
    chk("release_src1", res_src, 1);
    chk("release_data1", res_data, DB);
    cp_res_valid = 2'b00;
    tick();
    chk("drained_valid", res_valid, 0);

    // Result without credit -> sticky error; reset clears buffered result.
    rst_n = 0; tick(); rst_n = 1;
    #1;
    chk("err_clear", err, 0);
    set_res(0, 3'd4, DA, 5'd1, 1'b1);
    cp_res_valid = 2'b01; res_ready = 1;
    tick();
    cp_res_valid = 2'b00; res_ready = 0;
    #1;
    chk("err_set", err, 1);
    tick(); tick();
    chk("err_sticky", err, 1);
    chk("err_res_pending", res_valid, 1);
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_drop_valid", res_valid, 0);
    chk("rst_err_clear", err, 0);

    // Randomized traffic against the model.
    iss_hold = 0; res_hold = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!iss_hold) begin
        logic [6:0] op;
        case ($urandom % 5)
          0: op = 7'h0B;
          1: op = 7'h2B;
          2: op = 7'h33;
          3: op = 7'h5B;
          default: op = 7'h2B;
        endcase
        issue_valid = ($urandom % 3) != 0;
        issue_instr = $urandom;
        issue_instr[6:0] = op;
        issue_id = IW'($urandom);
        issue_rs = {$urandom, $urandom, $urandom, $urandom};
      end
      cp_issue_ready = N'($urandom);
      res_ready = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) begin
        if (!res_hold[k]) begin
          cp_res_valid[k] = (m_cnt[k] > 0 && ($urandom % 3) != 0) || ($urandom % 64 == 0);
          set_res(k, IW'($urandom), {$urandom, $urandom}, 5'($urandom), 1'($urandom));
        end
      end
      rst_n = ($urandom % 400) != 0;
      model_comb();
      iss_hold = rst_n && issue_valid && !e_ready;
      for (int k = 0; k < N; k++) res_hold[k] = rst_n && cp_res_valid[k] && !e_cprr[k];
      tick();
    end
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
